byte_fifo_src: RTL and testbench



---
 rtl/byte_fifo_src_if.sv | 40 ++++
 rtl/byte_fifo_src.sv | 104 ++++++++++
 tb/tb_byte_fifo_src.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/byte_fifo_src_if.sv
// Byte FIFO bus: producer write side, consumer read side and status.
// The optional err flag exists only when BYTE_FIFO_ERR_EN is defined.
//
// Handshake: a write is accepted at a rising edge when wr_en is high and
// full is low. A read is accepted at a rising edge when rd_en is high and
// empty is low. The byte read appears on dout one cycle later, and
// dout_valid is high for exactly that cycle.
interface byte_fifo_src_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        din;
  logic              rd_en;
  logic [7:0]        dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
`ifdef BYTE_FIFO_ERR_EN
  logic              err;
`endif

  // Producer and consumer side: drives requests and observes status.
  modport master (
    output wr_en, din, rd_en,
    input  dout, dout_valid, full, empty, count
`ifdef BYTE_FIFO_ERR_EN
    , input err
`endif
  );

  // FIFO side.
  modport slave (
    input  wr_en, din, rd_en,
    output dout, dout_valid, full, empty, count
`ifdef BYTE_FIFO_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/byte_fifo_src.sv
// byte_fifo_src: synchronous 8-bit FIFO that feeds a byte gating stage.
// dout is registered with one cycle of read latency. dout_valid pulses
// once for each accepted read. There is no pass-through when the FIFO is
// full and no fall-through when it is empty.
// Optional macro BYTE_FIFO_ERR_EN adds a sticky overflow/underflow flag
// called err.
module byte_fifo_src #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  byte_fifo_src_if.slave   fifo_bus
);
  localparam logic [ADDR_W:0]   LP_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_PTR_ONE = ADDR_W'(1);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic [7:0]        r_dout;
  logic              r_dout_valid;

  logic              w_full;
  logic              w_empty;
  logic              w_wa;
  logic              w_ra;

  // Status is decoded from the registered count, so it never depends on
  // the requests made in the same cycle.
  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_wa    = fifo_bus.wr_en & ~w_full;
  assign w_ra    = fifo_bus.rd_en & ~w_empty;

  assign fifo_bus.dout       = r_dout;
  assign fifo_bus.dout_valid = r_dout_valid;
  assign fifo_bus.full       = w_full;
  assign fifo_bus.empty      = w_empty;
  assign fifo_bus.count      = r_count;

  // Storage write. The contents do not need a reset because reads are
  // gated by count.
  always_ff @(posedge CLK) begin
    if (w_wa) begin
      r_mem[r_wptr] <= fifo_bus.din;
    end
  end

  // Pointers wrap naturally because they are exactly log2(DEPTH) bits wide.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wa) r_wptr <= r_wptr + LP_PTR_ONE;
      if (w_ra) r_rptr <= r_rptr + LP_PTR_ONE;
    end
  end

  // Occupancy changes only when exactly one side is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else begin
      case ({w_wa, w_ra})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered read port. dout holds its value between reads, and
  // dout_valid marks the single cycle a byte is delivered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dout       <= 8'h00;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_ra;
      if (w_ra) r_dout <= r_mem[r_rptr];
    end
  end

`ifdef BYTE_FIFO_ERR_EN
  logic r_err;

  // Sticky flag for a write while full or a read while empty.
  // Only reset clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if ((fifo_bus.wr_en & w_full) | (fifo_bus.rd_en & w_empty)) begin
      r_err <= 1'b1;
    end
  end

  assign fifo_bus.err = r_err;
`endif

endmodule

// File: tb/tb_byte_fifo_src.sv
// Self-checking bench for byte_fifo_src. The reference model is a byte queue.
// Each accepted read pushes the byte it should return into exp_q. A
// monitor pops exp_q whenever a delivery is due and compares it with dout.
module tb_byte_fifo_src;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic CLK;
  logic RST;

  byte_fifo_src_if #(.ADDR_W(ADDR_W)) bus ();

  byte_fifo_src #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .fifo_bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic       m_valid;
  logic       m_err;

  // Clock: 10 ns period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply the accept rules to the queue at each edge.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      model_q.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      logic wa, ra;
      wa = bus.wr_en && (model_q.size() < DEPTH);
      ra = bus.rd_en && (model_q.size() > 0);
      if ((bus.wr_en && model_q.size() == DEPTH) || (bus.rd_en && model_q.size() == 0))
        m_err = 1'b1;
      m_valid = ra;
      if (ra) exp_q.push_back(model_q.pop_front());
      if (wa) model_q.push_back(bus.din);
    end
  end

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (!RST) begin
      check("count", 32'(bus.count), 32'(model_q.size()));
      check("full",  32'(bus.full),  32'(model_q.size() == DEPTH));
      check("empty", 32'(bus.empty), 32'(model_q.size() == 0));
      check("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
`ifdef BYTE_FIFO_ERR_EN
      check("err", 32'(bus.err), 32'(m_err));
`endif
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard: delivery due with empty expected queue at %0t", $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("dout", 32'(bus.dout), 32'(e));
        end
      end
    end
  end

  // Driver: present one request set just after an active edge.
  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    @(posedge CLK);
    #2;
    bus.wr_en = w;
    bus.din   = d;
    bus.rd_en = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  // Assert reset between edges and confirm that it clears state before
  // the next edge arrives.
  task automatic async_reset();
    @(posedge CLK);
    #3;
    RST = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #1;
    check("rst_dout",       32'(bus.dout),       32'h00);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'h0);
    check("rst_empty",      32'(bus.empty),      32'h1);
    check("rst_full",       32'(bus.full),       32'h0);
    check("rst_count",      32'(bus.count),      32'h0);
`ifdef BYTE_FIFO_ERR_EN
    check("rst_err",        32'(bus.err),        32'h0);
`endif
    @(posedge CLK);
    #2;
    RST = 1'b0;
  endtask

  initial begin
    RST       = 1'b1;
    bus.wr_en = 1'b0;
    bus.din   = 8'h00;
    bus.rd_en = 1'b0;
    #12;
    RST = 1'b0;
    idle(2);
    async_reset();

    // Ordered transfer of three bytes.
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1);
    idle(2);

    // Fill to full, attempt an overflow write, then do a simultaneous
    // write and read while full, then drain.
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0);
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'hBB, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1);
    idle(2);

    // Simultaneous traffic starting at count 5.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h40 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h50 + 8'(i), 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b1);
    idle(2);

    // Simultaneous write and read while empty: no fall-through.
    drive(1'b1, 8'h5A, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    idle(2);

    // Randomly interleaved incrementing pattern across pointer wraps.
    begin
      int wv;
      wv = 0;
      for (int c = 0; c < 400 && wv < 40; c++) begin
        logic w;
        w = ($urandom_range(0, 2) != 0) && (model_q.size() < DEPTH);
        drive(w, 8'(wv), $urandom_range(0, 1) == 1);
        if (w) wv++;
      end
      for (int c = 0; c < DEPTH + 2; c++) drive(1'b0, 8'h00, 1'b1);
    end
    idle(2);

    // Fully random traffic that includes overflow and underflow attempts.
    for (int c = 0; c < 300; c++)
      drive($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1);
    idle(2);

    // Reset in the middle of operation discards buffered bytes.
    for (int i = 0; i < 6; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    async_reset();
    drive(1'b1, 8'h77, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    idle(2);

`ifdef BYTE_FIFO_ERR_EN
    // An underflow sets err, and err stays set through normal traffic.
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h12, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    idle(3);
    async_reset();
    idle(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
